// File: rtl/flappy_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flappy_game_ctrl
// Brief    : Flappy game-state engine: bird physics, pipe scroll/respawn,
//            collision detection and scoring, advanced once per frame tick.
// Revision : 1.0 - initial release
// ============================================================================
module flappy_game_ctrl #(
    parameter int SCREEN_W   = 640,
    parameter int GROUND_Y   = 480,
    parameter int BIRD_X     = 160,
    parameter int BIRD_W     = 16,
    parameter int BIRD_H     = 16,
    parameter int Y_START    = 240,
    parameter int GRAVITY    = 1,
    parameter int FLAP_V     = 8,
    parameter int VMAX       = 10,
    parameter int PIPE_W     = 40,
    parameter int PIPE_SPEED = 2,
    parameter int GAP_H      = 120
) (
    input  logic       ClkPort,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_flap,
    input  logic       start,
    output logic [9:0] BirdXdraw,
    output logic [9:0] BirdYdraw,
    output logic [9:0] X_Edge,
    output logic [9:0] gap_top,
    output logic [7:0] score,
    output logic       game_over,
    output logic       playing
);

    localparam logic [9:0]        c_gap_init = 10'd180;
    localparam logic [9:0]        c_gap_base = 10'd40;
    localparam logic [9:0]        c_screen_w = 10'(SCREEN_W);
    localparam logic [9:0]        c_y_start  = 10'(Y_START);
    localparam logic [9:0]        c_pipe_spd = 10'(PIPE_SPEED);
    localparam logic [9:0]        c_bird_x10 = 10'(BIRD_X);
    localparam logic [10:0]       c_ground_y = 11'(GROUND_Y);
    localparam logic [10:0]       c_bird_x   = 11'(BIRD_X);
    localparam logic [10:0]       c_bird_xr  = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0]       c_bird_h   = 11'(BIRD_H);
    localparam logic [10:0]       c_pipe_w   = 11'(PIPE_W);
    localparam logic [10:0]       c_gap_h    = 11'(GAP_H);
    localparam logic signed [6:0] c_gravity  = 7'(GRAVITY);
    localparam logic signed [6:0] c_vmax     = 7'(VMAX);
    localparam logic signed [5:0] c_flap_vel = 6'(-FLAP_V);
    localparam logic [7:0]        c_lfsr_rst = 8'hA5;
    localparam logic [7:0]        c_score_max = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [9:0]        r_bird_y;
    logic signed [5:0] r_vel;
    logic [9:0]        r_pipe_x;
    logic [9:0]        r_gap_top;
    logic [7:0]        r_score;
    logic [7:0]        r_lfsr;
    logic              r_flap_pend;
    logic              r_start_d;
    logic              r_flap_d;

    logic              w_start_rise;
    logic              w_flap_rise;
    logic              w_lfsr_fb;
    logic [10:0]       w_bird_bot;
    logic [10:0]       w_pipe_right;
    logic [10:0]       w_gap_bot;
    logic              w_hit_ground;
    logic              w_x_overlap;
    logic              w_gap_miss;
    logic              w_hit;
    logic              w_do_tick;
    logic signed [6:0] w_vel_inc;
    logic signed [5:0] w_vel_new;
    logic [10:0]       w_y_sum;
    logic [9:0]        w_y_next;
    logic signed [5:0] w_vel_next;
    logic              w_pipe_wrap;
    logic [9:0]        w_pipe_x_next;
    logic [9:0]        w_gap_next;
    logic              w_pass;

    assign w_start_rise = start & ~r_start_d;
    assign w_flap_rise  = btn_flap & ~r_flap_d;
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Collision terms are 11 bits wide so bottom/right edges never wrap.
    assign w_bird_bot   = {1'b0, r_bird_y} + c_bird_h;
    assign w_pipe_right = {1'b0, r_pipe_x} + c_pipe_w;
    assign w_gap_bot    = {1'b0, r_gap_top} + c_gap_h;
    assign w_hit_ground = (w_bird_bot >= c_ground_y);
    assign w_x_overlap  = (c_bird_x < w_pipe_right) && ({1'b0, r_pipe_x} < c_bird_xr);
    assign w_gap_miss   = (r_bird_y < r_gap_top) || (w_bird_bot > w_gap_bot);
    assign w_hit        = w_hit_ground || (w_x_overlap && w_gap_miss);

    // A collision in the same cycle as a tick wins; the frame update is dropped.
    assign w_do_tick    = (r_state == S_PLAY) && tick && !w_hit;

    assign w_vel_inc    = {r_vel[5], r_vel} + c_gravity;
    assign w_vel_new    = r_flap_pend          ? c_flap_vel :
                          (w_vel_inc > c_vmax) ? c_vmax[5:0] : w_vel_inc[5:0];
    assign w_y_sum      = {1'b0, r_bird_y} + {{5{w_vel_new[5]}}, w_vel_new};
    assign w_y_next     = w_y_sum[10] ? 10'd0 : w_y_sum[9:0];
    assign w_vel_next   = w_y_sum[10] ? 6'sd0 : w_vel_new;

    assign w_pipe_wrap   = (r_pipe_x < c_pipe_spd);
    assign w_pipe_x_next = w_pipe_wrap ? c_screen_w : (r_pipe_x - c_pipe_spd);
    assign w_gap_next    = c_gap_base + {2'b00, r_lfsr};
    assign w_pass        = (w_pipe_right >= c_bird_x) &&
                           (({1'b0, w_pipe_x_next} + c_pipe_w) < c_bird_x);

    always_ff @(posedge ClkPort) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        playing      = 1'b0;
        game_over    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) begin
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                playing = 1'b1;
                if (w_hit) begin
                    w_state_next = S_OVER;
                end
            end
            S_OVER: begin
                game_over = 1'b1;
                if (w_start_rise) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ClkPort) begin
        if (reset) begin
            r_bird_y    <= c_y_start;
            r_vel       <= 6'sd0;
            r_pipe_x    <= c_screen_w;
            r_gap_top   <= c_gap_init;
            r_score     <= 8'd0;
            r_lfsr      <= c_lfsr_rst;
            r_flap_pend <= 1'b0;
            r_start_d   <= 1'b0;
            r_flap_d    <= 1'b0;
        end else begin
            r_start_d <= start;
            r_flap_d  <= btn_flap;
            r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
            case (r_state)
                S_IDLE: begin
                    r_bird_y    <= c_y_start;
                    r_vel       <= 6'sd0;
                    r_pipe_x    <= c_screen_w;
                    r_gap_top   <= c_gap_init;
                    r_flap_pend <= 1'b0;
                    if (w_start_rise) begin
                        r_score <= 8'd0;
                    end
                end
                S_PLAY: begin
                    if (w_do_tick) begin
                        r_bird_y    <= w_y_next;
                        r_vel       <= w_vel_next;
                        r_pipe_x    <= w_pipe_x_next;
                        // A press landing on the consuming tick is kept for the next frame.
                        r_flap_pend <= w_flap_rise;
                        if (w_pipe_wrap) begin
                            r_gap_top <= w_gap_next;
                        end
                        if (w_pass && (r_score != c_score_max)) begin
                            r_score <= r_score + 8'd1;
                        end
                    end else if (w_flap_rise) begin
                        r_flap_pend <= 1'b1;
                    end
                end
                S_OVER: begin
                    r_flap_pend <= 1'b0;
                    if (w_start_rise) begin
                        r_bird_y  <= c_y_start;
                        r_vel     <= 6'sd0;
                        r_pipe_x  <= c_screen_w;
                        r_gap_top <= c_gap_init;
                    end
                end
                default: begin
                    r_flap_pend <= 1'b0;
                end
            endcase
        end
    end

    assign BirdXdraw = c_bird_x10;
    assign BirdYdraw = r_bird_y;
    assign X_Edge    = r_pipe_x;
    assign gap_top   = r_gap_top;
    assign score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_flappy_game_ctrl
// Brief    : Self-checking bench for flappy_game_ctrl with a game-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flappy_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       btn_flap = 1'b0;
    logic       start = 1'b0;
    logic [9:0] bird_x;
    logic [9:0] bird_y;
    logic [9:0] x_edge;
    logic [9:0] gap_top;
    logic [7:0] score;
    logic       game_over;
    logic       playing;

    always #5 clk = ~clk;

    flappy_game_ctrl dut (
        .ClkPort   (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_flap  (btn_flap),
        .start     (start),
        .BirdXdraw (bird_x),
        .BirdYdraw (bird_y),
        .X_Edge    (x_edge),
        .gap_top   (gap_top),
        .score     (score),
        .game_over (game_over),
        .playing   (playing)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: mode 0 = waiting, 1 = flying, 2 = crashed.
    int m_mode, m_y, m_vel, m_x, m_gap, m_score, m_lfsr;
    bit m_pend, m_start_d, m_flap_d;

    typedef struct {
        bit rst; bit tk; bit fl; bit st;
        int y;   int x;  int sc; bit ov; bit pl;
    } vec_t;
    vec_t tbl[$];

    int  ticks, frames, wraps, incs, sc_prev, x_before, g;
    bit  want;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_y = 240; m_vel = 0; m_x = 640; m_gap = 180; m_score = 0;
        m_lfsr = 8'hA5; m_pend = 0; m_start_d = 0; m_flap_d = 0;
    endtask

    task automatic model_step(input bit rst, input bit tk, input bit fl, input bit st);
        bit srise, frise, hit;
        int nv, ny, nx, fb;
        if (rst) begin
            model_reset();
            return;
        end
        srise = st && !m_start_d;
        frise = fl && !m_flap_d;
        m_start_d = st;
        m_flap_d  = fl;
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        hit = (m_y + 16 >= 480) ||
              ((m_x < 160 + 16) && (m_x + 40 > 160) &&
               ((m_y < m_gap) || (m_y + 16 > m_gap + 120)));
        case (m_mode)
            0: begin
                m_y = 240; m_vel = 0; m_x = 640; m_gap = 180; m_pend = 0;
                if (srise) begin m_mode = 1; m_score = 0; end
            end
            1: begin
                if (hit) begin
                    m_mode = 2;
                end else if (tk) begin
                    nv = m_pend ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
                    ny = m_y + nv;
                    if (ny < 0) begin ny = 0; nv = 0; end
                    if (m_x < 2) begin nx = 640; m_gap = 40 + m_lfsr; end
                    else nx = m_x - 2;
                    if ((m_x + 40 >= 160) && (nx + 40 < 160) && (m_score < 255))
                        m_score++;
                    m_y = ny; m_vel = nv; m_x = nx; m_pend = frise;
                end else if (frise) begin
                    m_pend = 1;
                end
            end
            default: begin
                m_pend = 0;
                if (srise) begin
                    m_mode = 0; m_y = 240; m_vel = 0; m_x = 640; m_gap = 180;
                end
            end
        endcase
        m_lfsr = ((m_lfsr << 1) | fb) & 255;
    endtask

    // Called at a falling edge: drive, clock once, then compare against the model.
    task automatic step(input bit rst, input bit tk, input bit fl, input bit st);
        reset = rst; tick = tk; btn_flap = fl; start = st;
        @(posedge clk);
        model_step(rst, tk, fl, st);
        @(negedge clk);
        chk("model_bird_x",  int'(bird_x),    160);
        chk("model_bird_y",  int'(bird_y),    m_y);
        chk("model_x_edge",  int'(x_edge),    m_x);
        chk("model_gap_top", int'(gap_top),   m_gap);
        chk("model_score",   int'(score),     m_score);
        chk("model_over",    int'(game_over), int'(m_mode == 2));
        chk("model_playing", int'(playing),   int'(m_mode == 1));
    endtask

    task automatic add(input bit r, input bit t, input bit f, input bit s,
                       input int y, input int x, input int sc, input bit ov, input bit pl);
        vec_t v;
        v.rst = r; v.tk = t; v.fl = f; v.st = s;
        v.y = y; v.x = x; v.sc = sc; v.ov = ov; v.pl = pl;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        //  rst tk fl st   y    x   sc ov pl
        add(1, 0, 0, 0,  240, 640, 0, 0, 0);
        add(0, 0, 0, 0,  240, 640, 0, 0, 0);
        add(0, 0, 0, 1,  240, 640, 0, 0, 1);
        add(0, 1, 0, 1,  241, 638, 0, 0, 1);
        add(0, 0, 0, 0,  241, 638, 0, 0, 1);
        add(0, 1, 0, 0,  243, 636, 0, 0, 1);
        add(0, 1, 0, 0,  246, 634, 0, 0, 1);
        add(0, 0, 1, 0,  246, 634, 0, 0, 1);
        add(0, 1, 1, 0,  238, 632, 0, 0, 1);
        add(0, 1, 0, 0,  231, 630, 0, 0, 1);
        add(0, 0, 0, 1,  231, 630, 0, 0, 1);
        add(1, 1, 1, 0,  240, 640, 0, 0, 0);
        add(0, 0, 0, 1,  240, 640, 0, 0, 1);
        add(0, 1, 0, 0,  241, 638, 0, 0, 1);
        add(0, 1, 0, 0,  243, 636, 0, 0, 1);
        add(0, 1, 0, 0,  246, 634, 0, 0, 1);
        add(0, 1, 0, 0,  250, 632, 0, 0, 1);
        add(0, 1, 0, 0,  255, 630, 0, 0, 1);
        add(0, 0, 1, 0,  255, 630, 0, 0, 1);
        add(0, 0, 0, 0,  255, 630, 0, 0, 1);
        add(0, 0, 1, 0,  255, 630, 0, 0, 1);
        add(0, 0, 0, 0,  255, 630, 0, 0, 1);
        add(0, 1, 0, 0,  247, 628, 0, 0, 1);
        add(0, 1, 0, 0,  240, 626, 0, 0, 1);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].tk, tbl[i].fl, tbl[i].st);
            chk($sformatf("vec%0d_y", i),       int'(bird_y),    tbl[i].y);
            chk($sformatf("vec%0d_x", i),       int'(x_edge),    tbl[i].x);
            chk($sformatf("vec%0d_score", i),   int'(score),     tbl[i].sc);
            chk($sformatf("vec%0d_over", i),    int'(game_over), int'(tbl[i].ov));
            chk($sformatf("vec%0d_playing", i), int'(playing),   int'(tbl[i].pl));
        end

        // Free fall from y=240, vel=-7: y reaches 464 on tick 36, crash seen one cycle later.
        ticks = 0;
        while (!game_over && ticks < 100) begin
            step(0, 1, 0, 0);
            ticks++;
        end
        chk("fall_game_over", int'(game_over), 1);
        chk("fall_cycles", ticks, 37);
        chk("fall_final_y", int'(bird_y), 464);
        chk("fall_final_x", int'(x_edge), 554);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, i[0], 0);
            chk("frozen_y", int'(bird_y), 464);
            chk("frozen_x", int'(x_edge), 554);
            chk("frozen_over", int'(game_over), 1);
        end
        step(0, 0, 0, 1);
        chk("restart_idle_y", int'(bird_y), 240);
        chk("restart_idle_x", int'(x_edge), 640);
        chk("restart_idle_gap", int'(gap_top), 180);
        chk("restart_idle_over", int'(game_over), 0);
        chk("restart_idle_playing", int'(playing), 0);

        // Steered flight through two full pipe passes and respawns.
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        wraps = 0; incs = 0; frames = 0; sc_prev = int'(score);
        while (wraps < 2 && frames < 1500 && playing && n_fail < 50) begin
            want = (m_y > m_gap + 60) && (m_vel >= 0) && !m_pend;
            step(0, 0, want, 0);
            repeat ($urandom_range(0, 2)) step(0, 0, 0, 0);
            x_before = m_x;
            step(0, 1, 0, 0);
            if (x_before < 2 && m_x == 640) begin
                wraps++;
                g = int'(gap_top);
                chk("respawn_gap_range", int'(g >= 40 && g <= 295), 1);
            end
            if (int'(score) != sc_prev) begin
                incs++;
                chk("score_step", int'(score) - sc_prev, 1);
                sc_prev = int'(score);
            end
            frames++;
        end
        chk("two_respawns", wraps, 2);
        chk("score_two_pipes", int'(score), 2);
        chk("score_increments", incs, 2);
        chk("survived_flight", int'(playing), 1);

        // Unconstrained random play, including restarts, crashes and rare resets.
        for (int i = 0; i < 3000 && n_fail < 50; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
